// File: rtl/tia_motion_pkg.sv
// Shared constants and types for the TIA HMOVE extra-clock sequencer.
package tia_motion_pkg;

  localparam int unsigned STEP_PERIOD_DFLT = 4;
  localparam int unsigned NUM_STEPS_DFLT   = 16;
  localparam int unsigned HMBL_LEN_DFLT    = 8;

  localparam int unsigned HM_W    = 4;
  localparam int unsigned NUM_OBJ = 5;

  localparam int unsigned OBJ_P0 = 0;
  localparam int unsigned OBJ_P1 = 1;
  localparam int unsigned OBJ_M0 = 2;
  localparam int unsigned OBJ_M1 = 3;
  localparam int unsigned OBJ_BL = 4;

  // Flipping the sign bit maps two's complement -8..+7 onto 0..15.
  localparam logic [HM_W-1:0] HM_BIAS = {1'b1, {(HM_W-1){1'b0}}};

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

endpackage

// File: rtl/tia_motion_latch.sv
// One object's motion register, enable latch and step compare.
module tia_motion_latch
  import tia_motion_pkg::*;
(
  input  logic            clk,
  input  logic            reset_bar,
  input  logic [HM_W-1:0] d,
  input  logic            we,
  input  logic            clr,
  input  logic            start,
  input  logic            step_strobe,
  input  logic [HM_W-1:0] step_idx,
  output logic            ec
);

  logic [HM_W-1:0] hm;
  logic [HM_W-1:0] hm_d;
  logic [HM_W-1:0] c_live;
  logic            en;
  logic            en_eff;
  logic            hit;

  // The compare looks ahead at the register value being written this edge,
  // so a write is seen by any step whose pulse lands in the following cycle.
  always_comb begin
    hm_d   = hm;
    if (clr) begin
      hm_d = '0;
    end else if (we) begin
      hm_d = d;
    end
    c_live = hm_d ^ HM_BIAS;
    en_eff = start | en;
    hit    = step_strobe & en_eff & (step_idx < c_live);
  end

  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      hm <= '0;
      en <= 1'b0;
      ec <= 1'b0;
    end else begin
      hm <= hm_d;
      en <= step_strobe ? hit : en_eff;
      ec <= hit;
    end
  end

endmodule

// File: rtl/tia_hmove_sequencer.sv
// HMOVE sequencer: step/phase FSM, HMOVE blank extension and five motion latches.
module tia_hmove_sequencer
  import tia_motion_pkg::*;
#(
  parameter int unsigned STEP_PERIOD = STEP_PERIOD_DFLT,
  parameter int unsigned NUM_STEPS   = NUM_STEPS_DFLT,
  parameter int unsigned HMBL_LEN    = HMBL_LEN_DFLT
) (
  input  logic            clk,
  input  logic            reset_bar,
  input  logic [HM_W-1:0] d,
  input  logic            p0hm,
  input  logic            p1hm,
  input  logic            m0hm,
  input  logic            m1hm,
  input  logic            blhm,
  input  logic            hmclr,
  input  logic            hmove,
  output logic            p0ec,
  output logic            p1ec,
  output logic            m0ec,
  output logic            m1ec,
  output logic            blec,
  output logic            hmbl,
  output logic            busy
);

  localparam int unsigned PHASE_W = (STEP_PERIOD > 1) ? $clog2(STEP_PERIOD) : 1;
  localparam int unsigned STEP_W  = HM_W;
  localparam int unsigned HMBL_W  = $clog2(HMBL_LEN + 1);

  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(STEP_PERIOD - 1);
  localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(NUM_STEPS - 1);

  state_e              state;
  state_e              state_d;
  logic [PHASE_W-1:0]  phase;
  logic [PHASE_W-1:0]  phase_d;
  logic [STEP_W-1:0]   step;
  logic [STEP_W-1:0]   step_d;
  logic [HMBL_W-1:0]   hmbl_cnt;
  logic [HMBL_W-1:0]   hmbl_cnt_d;
  logic                step_strobe_c;
  logic [NUM_OBJ-1:0]  we_vec;
  logic [NUM_OBJ-1:0]  ec_vec;

  // Next-state: hmove always (re)starts; otherwise walk phase then step.
  always_comb begin
    state_d = state;
    phase_d = phase;
    step_d  = step;
    if (hmove) begin
      state_d = RUN;
      phase_d = '0;
      step_d  = '0;
    end else if (state == RUN) begin
      if (phase == PHASE_LAST) begin
        phase_d = '0;
        if (step == STEP_LAST) begin
          state_d = IDLE;
          step_d  = '0;
        end else begin
          step_d = step + STEP_W'(1);
        end
      end else begin
        phase_d = phase + PHASE_W'(1);
      end
    end
    hmbl_cnt_d = hmbl_cnt;
    if (hmove) begin
      hmbl_cnt_d = HMBL_W'(HMBL_LEN);
    end else if (hmbl_cnt != '0) begin
      hmbl_cnt_d = hmbl_cnt - HMBL_W'(1);
    end
    step_strobe_c = (state_d == RUN) && (phase_d == '0);
  end

  always_ff @(posedge clk or negedge reset_bar) begin
    if (!reset_bar) begin
      state    <= IDLE;
      phase    <= '0;
      step     <= '0;
      hmbl_cnt <= '0;
      busy     <= 1'b0;
      hmbl     <= 1'b0;
    end else begin
      state    <= state_d;
      phase    <= phase_d;
      step     <= step_d;
      hmbl_cnt <= hmbl_cnt_d;
      busy     <= (state_d == RUN);
      hmbl     <= (hmbl_cnt_d != '0);
    end
  end

  always_comb begin
    we_vec         = '0;
    we_vec[OBJ_P0] = p0hm;
    we_vec[OBJ_P1] = p1hm;
    we_vec[OBJ_M0] = m0hm;
    we_vec[OBJ_M1] = m1hm;
    we_vec[OBJ_BL] = blhm;
  end

  for (genvar g = 0; g < NUM_OBJ; g++) begin : g_obj
    tia_motion_latch u_latch (
      .clk         (clk),
      .reset_bar   (reset_bar),
      .d           (d),
      .we          (we_vec[g]),
      .clr         (hmclr),
      .start       (hmove),
      .step_strobe (step_strobe_c),
      .step_idx    (step_d),
      .ec          (ec_vec[g])
    );
  end

  assign p0ec = ec_vec[OBJ_P0];
  assign p1ec = ec_vec[OBJ_P1];
  assign m0ec = ec_vec[OBJ_M0];
  assign m1ec = ec_vec[OBJ_M1];
  assign blec = ec_vec[OBJ_BL];

endmodule

// File: tb/tb_tia_hmove_sequencer.sv
// Directed bench for tia_hmove_sequencer: pulse counts, slot timing, busy/hmbl windows.
module tb_tia_hmove_sequencer;

  logic       clk = 1'b0;
  logic       reset_bar = 1'b0;
  logic [3:0] d = 4'h0;
  logic       p0hm = 1'b0, p1hm = 1'b0, m0hm = 1'b0, m1hm = 1'b0, blhm = 1'b0;
  logic       hmclr = 1'b0, hmove = 1'b0;
  logic       p0ec, p1ec, m0ec, m1ec, blec, hmbl, busy;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  int k;
  int cnt [5];
  int busy_n, hmbl_n, bad_slot;
  int busy_first, busy_last, hmbl_first, hmbl_last;

  tia_hmove_sequencer dut (
    .clk       (clk),
    .reset_bar (reset_bar),
    .d         (d),
    .p0hm      (p0hm),
    .p1hm      (p1hm),
    .m0hm      (m0hm),
    .m1hm      (m1hm),
    .blhm      (blhm),
    .hmclr     (hmclr),
    .hmove     (hmove),
    .p0ec      (p0ec),
    .p1ec      (p1ec),
    .m0ec      (m0ec),
    .m1ec      (m1ec),
    .blec      (blec),
    .hmbl      (hmbl),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic clear_stats();
    for (int o = 0; o < 5; o++) cnt[o] = 0;
    busy_n = 0; hmbl_n = 0; bad_slot = 0;
    busy_first = -1; busy_last = -1; hmbl_first = -1; hmbl_last = -1;
  endtask

  // Sample the current cycle (k cycles after the last hmove edge), then advance.
  task automatic cycle();
    logic [4:0] e;
    e = {blec, m1ec, m0ec, p1ec, p0ec};
    for (int o = 0; o < 5; o++) if (e[o]) cnt[o]++;
    if (e != 5'b0 && ((((k - 1) % 4) != 0) || !busy)) bad_slot++;
    if (busy) begin
      busy_n++;
      if (busy_first < 0) busy_first = k;
      busy_last = k;
    end
    if (hmbl) begin
      hmbl_n++;
      if (hmbl_first < 0) hmbl_first = k;
      hmbl_last = k;
    end
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic write_hm(input int obj, input logic [3:0] v);
    d = v;
    case (obj)
      0: p0hm = 1'b1;
      1: p1hm = 1'b1;
      2: m0hm = 1'b1;
      3: m1hm = 1'b1;
      default: blhm = 1'b1;
    endcase
    cycle();
    {p0hm, p1hm, m0hm, m1hm, blhm} = 5'b0;
  endtask

  task automatic do_hmclr();
    hmclr = 1'b1;
    cycle();
    hmclr = 1'b0;
  endtask

  task automatic do_hmove();
    hmove = 1'b1;
    cycle();
    hmove = 1'b0;
    k = 1;
  endtask

  task automatic test_reset();
    logic [6:0] o;
    o = {p0ec, p1ec, m0ec, m1ec, blec, hmbl, busy};
    chk_cnt++;
    if (o !== 7'b0) $display("FAIL reset_outputs: got %b expected %b", o, 7'b0);
    else pass_cnt++;
    reset_bar = 1'b1;
    clear_stats();
    k = 100;
    repeat (10) cycle();
    chk_cnt++;
    if (busy_n + hmbl_n + cnt[0] + cnt[1] + cnt[2] + cnt[3] + cnt[4] !== 0)
      $display("FAIL reset_release_quiet: got %0d active samples expected 0",
               busy_n + hmbl_n + cnt[0] + cnt[1] + cnt[2] + cnt[3] + cnt[4]);
    else pass_cnt++;
  endtask

  task automatic test_static_counts();
    int exp_c [5];
    exp_c = '{0, 7, 8, 11, 15};
    write_hm(0, 4'h8);
    write_hm(1, 4'hF);
    write_hm(2, 4'h0);
    write_hm(3, 4'h3);
    write_hm(4, 4'h7);
    clear_stats();
    do_hmove();
    clear_stats();
    repeat (70) cycle();
    for (int o = 0; o < 5; o++) begin
      chk_cnt++;
      if (cnt[o] !== exp_c[o]) $display("FAIL static_count obj%0d: got %0d expected %0d", o, cnt[o], exp_c[o]);
      else pass_cnt++;
    end
    chk_cnt++;
    if (busy_n !== 64) $display("FAIL static_busy_len: got %0d expected 64", busy_n);
    else pass_cnt++;
    chk_cnt++;
    if (busy_first !== 1 || busy_last !== 64)
      $display("FAIL static_busy_window: got %0d..%0d expected 1..64", busy_first, busy_last);
    else pass_cnt++;
    chk_cnt++;
    if (hmbl_n !== 8 || hmbl_first !== 1 || hmbl_last !== 8)
      $display("FAIL static_hmbl_window: got %0d cycles %0d..%0d expected 8 cycles 1..8", hmbl_n, hmbl_first, hmbl_last);
    else pass_cnt++;
    chk_cnt++;
    if (bad_slot !== 0) $display("FAIL static_pulse_slots: got %0d misplaced expected 0", bad_slot);
    else pass_cnt++;
  endtask

  task automatic test_hmclr();
    for (int o = 0; o < 5; o++) write_hm(o, 4'h7);
    do_hmclr();
    do_hmove();
    clear_stats();
    repeat (70) cycle();
    for (int o = 0; o < 5; o++) begin
      chk_cnt++;
      if (cnt[o] !== 8) $display("FAIL hmclr_count obj%0d: got %0d expected 8", o, cnt[o]);
      else pass_cnt++;
    end
  endtask

  task automatic test_live_write();
    write_hm(4, 4'h7);
    do_hmove();
    clear_stats();
    repeat (9) cycle();
    write_hm(4, 4'h8);
    repeat (19) cycle();
    write_hm(4, 4'h7);
    repeat (40) cycle();
    chk_cnt++;
    if (cnt[4] !== 3) $display("FAIL live_bl_count: got %0d expected 3", cnt[4]);
    else pass_cnt++;
    chk_cnt++;
    if (cnt[0] !== 8) $display("FAIL live_p0_count: got %0d expected 8", cnt[0]);
    else pass_cnt++;
    chk_cnt++;
    if (bad_slot !== 0) $display("FAIL live_pulse_slots: got %0d misplaced expected 0", bad_slot);
    else pass_cnt++;
  endtask

  task automatic test_restart();
    write_hm(0, 4'h7);
    do_hmove();
    clear_stats();
    repeat (20) cycle();
    do_hmove();
    chk_cnt++;
    if (cnt[0] !== 6) $display("FAIL restart_pre_count: got %0d expected 6", cnt[0]);
    else pass_cnt++;
    clear_stats();
    repeat (70) cycle();
    chk_cnt++;
    if (cnt[0] !== 15) $display("FAIL restart_post_count: got %0d expected 15", cnt[0]);
    else pass_cnt++;
    chk_cnt++;
    if (busy_first !== 1 || busy_last !== 64 || busy_n !== 64)
      $display("FAIL restart_busy_window: got %0d..%0d (%0d) expected 1..64 (64)", busy_first, busy_last, busy_n);
    else pass_cnt++;
    chk_cnt++;
    if (hmbl_first !== 1 || hmbl_last !== 8 || hmbl_n !== 8)
      $display("FAIL restart_hmbl_window: got %0d..%0d (%0d) expected 1..8 (8)", hmbl_first, hmbl_last, hmbl_n);
    else pass_cnt++;
    chk_cnt++;
    if (bad_slot !== 0) $display("FAIL restart_pulse_slots: got %0d misplaced expected 0", bad_slot);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [6:0] o;
    for (int j = 0; j < 5; j++) write_hm(j, 4'h7);
    do_hmove();
    repeat (19) cycle();
    #2;
    reset_bar = 1'b0;
    #1;
    o = {p0ec, p1ec, m0ec, m1ec, blec, hmbl, busy};
    chk_cnt++;
    if (o !== 7'b0) $display("FAIL midreset_outputs: got %b expected %b", o, 7'b0);
    else pass_cnt++;
    repeat (2) @(posedge clk);
    #1;
    reset_bar = 1'b1;
    clear_stats();
    repeat (80) cycle();
    chk_cnt++;
    if (busy_n + hmbl_n + cnt[0] + cnt[1] + cnt[2] + cnt[3] + cnt[4] !== 0)
      $display("FAIL midreset_quiet: got %0d active samples expected 0",
               busy_n + hmbl_n + cnt[0] + cnt[1] + cnt[2] + cnt[3] + cnt[4]);
    else pass_cnt++;
    do_hmove();
    clear_stats();
    repeat (70) cycle();
    for (int j = 0; j < 5; j++) begin
      chk_cnt++;
      if (cnt[j] !== 8) $display("FAIL midreset_count obj%0d: got %0d expected 8", j, cnt[j]);
      else pass_cnt++;
    end
  endtask

  task automatic test_idle_quiet();
    clear_stats();
    repeat (100) begin
      write_hm(int'($urandom_range(0, 4)), 4'($urandom));
      cycle();
    end
    chk_cnt++;
    if (cnt[0] + cnt[1] + cnt[2] + cnt[3] + cnt[4] !== 0)
      $display("FAIL idle_pulses: got %0d expected 0", cnt[0] + cnt[1] + cnt[2] + cnt[3] + cnt[4]);
    else pass_cnt++;
    chk_cnt++;
    if (busy_n !== 0) $display("FAIL idle_busy: got %0d expected 0", busy_n);
    else pass_cnt++;
    chk_cnt++;
    if (hmbl_n !== 0) $display("FAIL idle_hmbl: got %0d expected 0", hmbl_n);
    else pass_cnt++;
  endtask

  initial begin
    k = 0;
    clear_stats();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_static_counts();
    test_hmclr();
    test_live_write();
    test_restart();
    test_reset_mid();
    test_idle_quiet();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
